lcd_reset_sequencer: RTL and testbench

- Sits directly downstream of the LCD reset PIO. Consumes the software-written reset request bit and drives the panel's RESX pin with guaranteed timing.
- Enforces a minimum reset-low pulse width.
- Enforces the panel's post-reset settling delay before reporting the panel ready.
- ready/busy/done feed the LCD bus interface, which must not issue commands before ready=1.

---
 rtl/lcd_reset_sequencer.sv | 112 +++++++++++
 tb/tb_lcd_reset_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lcd_reset_sequencer.sv
// Drives the LCD panel RESX pin from the software reset request, enforcing a minimum
// reset-low pulse width and a post-reset settling delay before reporting the panel ready.
module lcd_reset_sequencer #(
    parameter int unsigned LOW_CYCLES  = 500,
    parameter int unsigned WAIT_CYCLES = 6000000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_n,
    output logic       lcd_rst_n,
    output logic       busy,
    output logic       ready,
    output logic       done,
    output logic [7:0] seq_count
);

    typedef enum logic [1:0] {StHold, StSettle, StReady} state_e;

    localparam logic [CNT_W-1:0] LowMax   = CNT_W'(LOW_CYCLES);
    localparam logic [CNT_W-1:0] LowLast  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lcd_rst_n_q, lcd_rst_n_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [7:0]         seq_count_q, seq_count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            lcd_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            seq_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcd_rst_n_q <= lcd_rst_n_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            seq_count_q <= seq_count_d;
        end
    end

    // Abort (req_n=0) takes priority over settle completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StHold: begin
                if (req_n && (cnt_q >= LowLast)) state_d = StSettle;
            end
            StSettle: begin
                if (!req_n)                 state_d = StHold;
                else if (cnt_q == WaitLast) state_d = StReady;
            end
            StReady: begin
                if (!req_n) state_d = StHold;
            end
            default: state_d = StHold;
        endcase
    end

    // Registered outputs are derived from the state being entered, so they change on the
    // same edge as the state. cnt restarts at 0 on every state change.
    always_comb begin
        cnt_d       = '0;
        lcd_rst_n_d = 1'b0;
        busy_d      = 1'b1;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        seq_count_d = seq_count_q;
        case (state_d)
            StHold: begin
                if (state_q == StHold) begin
                    cnt_d = (cnt_q < LowMax) ? cnt_q + CntOne : cnt_q;
                end
                busy_d = (cnt_d < LowMax);
            end
            StSettle: begin
                lcd_rst_n_d = 1'b1;
                if (state_q == StSettle) cnt_d = cnt_q + CntOne;
            end
            StReady: begin
                lcd_rst_n_d = 1'b1;
                busy_d      = 1'b0;
                ready_d     = 1'b1;
                if (state_q == StSettle) begin
                    done_d = 1'b1;
                    if (seq_count_q != 8'd255) seq_count_d = seq_count_q + 8'd1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign lcd_rst_n = lcd_rst_n_q;
    assign busy      = busy_q;
    assign ready     = ready_q;
    assign done      = done_q;
    assign seq_count = seq_count_q;

endmodule

// File: tb/tb_lcd_reset_sequencer.sv
// Directed bench for lcd_reset_sequencer with LOW_CYCLES=4, WAIT_CYCLES=8: a per-cycle
// vector table for the main flow plus hand-written async-reset, short-pulse and saturation runs.
module tb_lcd_reset_sequencer;

    localparam int unsigned Low  = 4;
    localparam int unsigned Wait = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_n;
    logic       lcd_rst_n;
    logic       busy;
    logic       ready;
    logic       done;
    logic [7:0] seq_count;

    lcd_reset_sequencer #(
        .LOW_CYCLES  (Low),
        .WAIT_CYCLES (Wait),
        .CNT_W       (24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_n     (req_n),
        .lcd_rst_n (lcd_rst_n),
        .busy      (busy),
        .ready     (ready),
        .done      (done),
        .seq_count (seq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req_n;
        logic       lcd;
        logic       busy;
        logic       ready;
        logic       done;
        logic [7:0] seq;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic r, input logic l, input logic b, input logic rd,
                                input logic d, input logic [7:0] s);
        vec_t v;
        v.req_n = r;
        v.lcd   = l;
        v.busy  = b;
        v.ready = rd;
        v.done  = d;
        v.seq   = s;
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] outs();
        return {lcd_rst_n, busy, ready, done, seq_count};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got lcd/busy/ready/done=%b seq=%0d, required %b seq=%0d",
                     name, act[11:8], act[7:0], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int         k;
        logic [7:0] exp_seq;

        reset = 1'b1;
        req_n = 1'b0;
        repeat (3) tick();
        check("reset_values", outs(), {4'b0100, 8'd0});
        reset = 1'b0;

        // Reset and release: park in reset, then release and settle.
        for (int i = 1; i <= 10; i++) add(1'b0, 1'b0, (i < 4), 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 7; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
        // Drop from READY: busy for 4 cycles then idle.
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        for (int i = 1; i <= 3; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        // Release, abort at SETTLE cnt=5, new 4-cycle low pulse.
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        for (int i = 1; i <= 5; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        for (int i = 1; i <= 3; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        // Abort coincident with completion at cnt=7.
        for (int i = 1; i <= 7; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        for (int i = 1; i <= 3; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        for (int i = 1; i <= 7; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);

        foreach (vecs[i]) begin
            req_n = vecs[i].req_n;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].lcd, vecs[i].busy, vecs[i].ready, vecs[i].done, vecs[i].seq});
        end

        // Async reset mid-SETTLE, asserted between edges.
        req_n = 1'b0;
        tick();
        req_n = 1'b1;
        repeat (6) tick();
        check("pre_async_settle", outs(), {4'b1100, 8'd2});
        #2 reset = 1'b1;
        #1 check("async_reset", outs(), {4'b0100, 8'd0});
        repeat (2) tick();

        // Short request pulse right after reset release.
        reset = 1'b0;
        req_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("short_low%0d", i), outs(), {4'b0100, 8'd0});
        end
        tick();
        check("short_rise", outs(), {4'b1100, 8'd0});
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("short_settle%0d", i), outs(), {4'b1100, 8'd0});
        end
        tick();
        check("short_ready", outs(), {4'b1011, 8'd1});

        // Saturation of the sequence counter.
        exp_seq = 8'd1;
        for (int s = 0; s < 260; s++) begin
            req_n = 1'b0;
            tick();
            req_n = 1'b1;
            k = 0;
            while (!ready && k < 40) begin
                tick();
                k++;
            end
            if (k >= 40) begin
                n_vec++;
                n_bad++;
                $display("FAIL sat_timeout%0d: got ready=0 after 40 cycles, required ready=1", s);
            end else begin
                exp_seq = (exp_seq < 8'd255) ? exp_seq + 8'd1 : 8'd255;
                check($sformatf("sat_seq%0d", s), outs(), {4'b1011, exp_seq});
            end
        end
        check("sat_final", {4'b0000, seq_count}, {4'b0000, 8'd255});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
